joypad_if: RTL and testbench

JOYPAD_IF -- requirements
Module: joypad_if

---
 rtl/joypad_if.sv | 173 +++++++++++++++++
 tb/tb_joypad_if.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/joypad_if.sv
// Two-controller joypad interface: a periodic scan engine clocks eight
// buttons out of each pad into snapshot registers, and a CPU-facing
// strobe/shift port at 16'h4016/16'h4017 serialises those snapshots.
module joypad_if #(
  parameter int POLL_CYCLES = 833333,
  parameter int HALF_CYCLES = 300
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr,
  input  logic [15:0] addr,
  input  logic        din,
  input  logic        jp_data1,
  input  logic        jp_data2,
  output logic        jp_clk,
  output logic        jp_latch,
  output logic [7:0]  dout
);

  localparam logic [15:0] ADDR_PAD1  = 16'h4016;
  localparam logic [15:0] ADDR_PAD2  = 16'h4017;
  localparam logic [31:0] POLL_LAST  = 32'(POLL_CYCLES - 1);
  localparam logic [31:0] HALF_LAST  = 32'(HALF_CYCLES - 1);
  localparam logic [31:0] LATCH_LAST = 32'(2 * HALF_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    CLK_LO,
    CLK_HI,
    COMMIT
  } scan_state_t;

  scan_state_t state, state_next;

  logic [31:0] poll_cnt;
  logic [31:0] phase_cnt, phase_next;
  logic [2:0]  bit_idx, bit_idx_next;
  logic        poll_wrap;
  logic        sample_now;
  logic        commit_now;

  logic [7:0]  scratch1, scratch2;
  logic [7:0]  snap1, snap2;
  logic [7:0]  sr1, sr2;
  logic        strobe;
  logic        rd1_q, rd2_q;

  logic        rd1, rd2;
  logic        rd1_event, rd2_event;
  logic        strobe_wr;

  // The poll counter free-runs and wraps at POLL_CYCLES-1; because a scan is
  // shorter than the poll period, the wrap always lands in IDLE (or in COMMIT
  // at the tightest legal setting), so scan starts are exactly one period apart.
  assign poll_wrap = (poll_cnt == POLL_LAST);

  // Scan FSM next-state logic: phase counter times each half-phase,
  // bit index walks the eight buttons.
  always_comb begin
    state_next   = state;
    phase_next   = phase_cnt + 32'd1;
    bit_idx_next = bit_idx;
    sample_now   = 1'b0;
    commit_now   = 1'b0;
    case (state)
      IDLE: begin
        phase_next = 32'd0;
        if (poll_wrap) state_next = LATCH;
      end
      LATCH: begin
        if (phase_cnt == LATCH_LAST) begin
          state_next   = CLK_LO;
          phase_next   = 32'd0;
          bit_idx_next = 3'd0;
        end
      end
      CLK_LO: begin
        if (phase_cnt == HALF_LAST) begin
          sample_now = 1'b1;
          state_next = CLK_HI;
          phase_next = 32'd0;
        end
      end
      CLK_HI: begin
        if (phase_cnt == HALF_LAST) begin
          bit_idx_next = bit_idx + 3'd1;
          phase_next   = 32'd0;
          state_next   = (bit_idx == 3'd7) ? COMMIT : CLK_LO;
        end
      end
      COMMIT: begin
        commit_now = 1'b1;
        phase_next = 32'd0;
        state_next = poll_wrap ? LATCH : IDLE;
      end
      default: begin
        state_next = IDLE;
        phase_next = 32'd0;
      end
    endcase
  end

  // Scan state register; pad pins are registered from the next state so they
  // line up exactly with the state they belong to, and a reset drops them at once.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      poll_cnt  <= 32'd0;
      phase_cnt <= 32'd0;
      bit_idx   <= 3'd0;
      jp_clk    <= 1'b0;
      jp_latch  <= 1'b0;
      scratch1  <= 8'h00;
      scratch2  <= 8'h00;
      snap1     <= 8'h00;
      snap2     <= 8'h00;
    end else begin
      state     <= state_next;
      poll_cnt  <= poll_wrap ? 32'd0 : poll_cnt + 32'd1;
      phase_cnt <= phase_next;
      bit_idx   <= bit_idx_next;
      jp_latch  <= (state_next == LATCH);
      jp_clk    <= (state_next == CLK_HI);
      if (sample_now) begin
        scratch1[bit_idx] <= ~jp_data1;
        scratch2[bit_idx] <= ~jp_data2;
      end
      if (commit_now) begin
        snap1 <= scratch1;
        snap2 <= scratch2;
      end
    end
  end

  // A read only counts on its first cycle, so a held bus read shifts once.
  assign rd1       = !wr && (addr == ADDR_PAD1);
  assign rd2       = !wr && (addr == ADDR_PAD2);
  assign strobe_wr = wr && (addr == ADDR_PAD1);
  assign rd1_event = rd1 && !rd1_q;
  assign rd2_event = rd2 && !rd2_q;

  // CPU port: strobe register, read-edge tracker and the two serial shifters;
  // a strobe write wins over any shift in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      strobe <= 1'b0;
      rd1_q  <= 1'b0;
      rd2_q  <= 1'b0;
      sr1    <= 8'h00;
      sr2    <= 8'h00;
    end else begin
      rd1_q <= rd1;
      rd2_q <= rd2;
      if (strobe_wr) strobe <= din;
      if (strobe) begin
        sr1 <= snap1;
        sr2 <= snap2;
      end else if (!strobe_wr) begin
        if (rd1_event) sr1 <= {1'b1, sr1[7:1]};
        if (rd2_event) sr2 <= {1'b1, sr2[7:1]};
      end
    end
  end

  // Read data is zero unless this block is addressed, so it can be OR-ed onto the bus.
  always_comb begin
    dout = 8'h00;
    if (rd1)      dout = {7'b0, sr1[0]};
    else if (rd2) dout = {7'b0, sr2[0]};
  end

endmodule

// File: tb/tb_joypad_if.sv
// Scoreboard bench for joypad_if: stimulus pushes expected read/pin values,
// a negedge monitor pops and compares them, and also checks every scan
// waveform and the spacing between scan starts.
module tb_joypad_if;

  localparam int POLL = 100;
  localparam int HALF = 2;
  localparam int KIND_NONE = 0;
  localparam int KIND_DOUT = 1;
  localparam int KIND_PINS = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr = 1'b0;
  logic [15:0] addr = 16'h0000;
  logic        din = 1'b0;
  logic        jp_data1;
  logic        jp_data2;
  logic        jp_clk;
  logic        jp_latch;
  logic [7:0]  dout;

  // Pad model state: pressed-button patterns and the pad shift registers.
  logic [7:0]  pat1 = 8'h00;
  logic [7:0]  pat2 = 8'h00;
  logic [7:0]  sh1 = 8'h00;
  logic [7:0]  sh2 = 8'h00;
  logic        pad_clk_q = 1'b0;

  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  logic        mon_req = 1'b0;
  logic [7:0]  exp_q[$];
  int          kind_q[$];
  string       name_q[$];

  logic        first_rise = 1'b1;
  logic        prev_latch = 1'b0;
  int          last_rise = 0;
  int          shape_pos = -1;
  int          shape_err = 0;
  logic [7:0]  mon_exp;
  int          mon_kind;
  string       mon_name;
  logic        exp_l;
  logic        exp_c;

  joypad_if #(
    .POLL_CYCLES(POLL),
    .HALF_CYCLES(HALF)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .wr      (wr),
    .addr    (addr),
    .din     (din),
    .jp_data1(jp_data1),
    .jp_data2(jp_data2),
    .jp_clk  (jp_clk),
    .jp_latch(jp_latch),
    .dout    (dout)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Cycle index since the last clock edge that sampled reset.
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // Pad model: parallel load while latched, shift on each rising pad clock.
  always @(posedge clk) begin
    if (jp_latch) begin
      sh1 <= pat1;
      sh2 <= pat2;
    end else if (jp_clk && !pad_clk_q) begin
      sh1 <= sh1 >> 1;
      sh2 <= sh2 >> 1;
    end
    pad_clk_q <= jp_clk;
  end

  assign jp_data1 = ~sh1[0];
  assign jp_data2 = ~sh2[0];

  task automatic checkOutput(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cyc %0d)", name, act, expv, cyc);
    end
  endtask

  // Monitor: scoreboard pops plus scan waveform and period checks.
  always @(negedge clk) begin
    if (mon_req) begin
      if (exp_q.size() == 0) begin
        checkOutput("sb_underflow", 1, 0);
      end else begin
        mon_exp  = exp_q.pop_front();
        mon_kind = kind_q.pop_front();
        mon_name = name_q.pop_front();
        if (mon_kind == KIND_PINS) checkOutput(mon_name, {30'b0, jp_latch, jp_clk}, int'(mon_exp));
        else                       checkOutput(mon_name, int'(dout), int'(mon_exp));
      end
    end
    if (rst) begin
      first_rise = 1'b1;
      shape_pos  = -1;
    end else begin
      if (jp_latch && !prev_latch) begin
        if (first_rise) checkOutput("first_latch_cycle", cyc, POLL);
        else            checkOutput("latch_period", cyc - last_rise, POLL);
        first_rise = 1'b0;
        last_rise  = cyc;
        shape_pos  = 0;
        shape_err  = 0;
      end
      if (shape_pos >= 0) begin
        exp_l = (shape_pos < 2 * HALF);
        exp_c = (shape_pos >= 2 * HALF && shape_pos < 18 * HALF) ?
                (((shape_pos - 2 * HALF) % (2 * HALF)) >= HALF) : 1'b0;
        if (jp_latch !== exp_l || jp_clk !== exp_c) shape_err++;
        if (shape_pos == 18 * HALF + 1) begin
          checkOutput("scan_shape", shape_err, 0);
          shape_pos = -1;
        end else begin
          shape_pos++;
        end
      end
    end
    prev_latch = jp_latch;
  end

  task automatic applyStimulus(input logic w, input logic [15:0] a, input logic d,
                               input int kind, input logic [7:0] expv, input string name);
    wr   = w;
    addr = a;
    din  = d;
    if (kind != KIND_NONE) begin
      exp_q.push_back(expv);
      kind_q.push_back(kind);
      name_q.push_back(name);
      mon_req = 1'b1;
    end else begin
      mon_req = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 16'h0000, 1'b0, KIND_NONE, 8'h00, "");
  endtask

  task automatic waitCycle(input int n);
    wr = 1'b0; addr = 16'h0000; din = 1'b0; mon_req = 1'b0;
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic readBit(input logic [15:0] a, input logic b, input string name);
    applyStimulus(1'b0, a, 1'b0, KIND_DOUT, {7'b0, b}, name);
    idleCycle();
  endtask

  task automatic strobeReload();
    applyStimulus(1'b1, 16'h4016, 1'b1, KIND_NONE, 8'h00, "");
    applyStimulus(1'b1, 16'h4016, 1'b0, KIND_NONE, 8'h00, "");
  endtask

  // Eight reads of the given button pattern, then one read past the end.
  task automatic readSeq(input logic [15:0] a, input logic [7:0] bits, input string name);
    for (int i = 0; i < 8; i++) readBit(a, bits[i], name);
    readBit(a, 1'b1, {name, "_tail"});
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    @(posedge clk);
    #1;
    idleCycle();
    idleCycle();
    applyStimulus(1'b0, 16'h4016, 1'b0, KIND_DOUT, 8'h00, "rst_dout_4016");
    applyStimulus(1'b0, 16'h4017, 1'b0, KIND_DOUT, 8'h00, "rst_dout_4017");
    applyStimulus(1'b0, 16'h0000, 1'b0, KIND_PINS, 8'h00, "rst_pins");
    rst = 1'b0;

    // First scan with lines idle-high: nothing pressed.
    waitCycle(140);
    strobeReload();
    readSeq(16'h4016, 8'h00, "snap1_idle");
    readSeq(16'h4017, 8'h00, "snap2_idle");
    pat1 = 8'h09;
    pat2 = 8'hA5;

    // Second scan captures A+Start on pad 1 and 8'hA5 on pad 2.
    waitCycle(240);
    strobeReload();
    readSeq(16'h4016, 8'h09, "pad1_seq");
    readSeq(16'h4017, 8'hA5, "pad2_seq");

    // Held read shifts only once.
    strobeReload();
    applyStimulus(1'b0, 16'h4016, 1'b0, KIND_DOUT, 8'h01, "hold_c0");
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b0, 16'h4016, 1'b0, KIND_DOUT, 8'h00, "hold_cn");
    idleCycle();
    readBit(16'h4016, 1'b0, "after_hold_b1");
    readBit(16'h4016, 1'b0, "after_hold_b2");
    readBit(16'h4016, 1'b1, "after_hold_b3");

    // Strobe held high: reads keep returning A; unmapped addresses read 0.
    applyStimulus(1'b1, 16'h4016, 1'b1, KIND_DOUT, 8'h00, "wr_cycle_dout");
    idleCycle();
    readBit(16'h4016, 1'b1, "strobe_rd1");
    readBit(16'h4016, 1'b1, "strobe_rd2");
    readBit(16'h4016, 1'b1, "strobe_rd3");
    readBit(16'h4017, 1'b1, "strobe_rd_p2");
    readBit(16'h4015, 1'b0, "unmapped_4015");
    readBit(16'h2002, 1'b0, "unmapped_2002");
    applyStimulus(1'b1, 16'h4017, 1'b0, KIND_NONE, 8'h00, "");
    readBit(16'h4016, 1'b1, "wr4017_no_strobe1");
    readBit(16'h4016, 1'b1, "wr4017_no_strobe2");
    applyStimulus(1'b1, 16'h4016, 1'b0, KIND_NONE, 8'h00, "");
    idleCycle();

    // A commit during a strobe-0 read sequence leaves the shifter alone.
    waitCycle(350);
    pat1 = 8'hFF;
    waitCycle(420);
    strobeReload();
    readBit(16'h4016, 1'b1, "old_b0");
    readBit(16'h4016, 1'b0, "old_b1");
    readBit(16'h4016, 1'b0, "old_b2");
    waitCycle(440);
    readBit(16'h4016, 1'b1, "old_b3");
    readBit(16'h4016, 1'b0, "old_b4");
    readBit(16'h4016, 1'b0, "old_b5");
    readBit(16'h4016, 1'b0, "old_b6");
    readBit(16'h4016, 1'b0, "old_b7");
    readBit(16'h4016, 1'b1, "old_tail");
    strobeReload();
    readSeq(16'h4016, 8'hFF, "new_ff");

    // Reset during CLK_HI of bit 4 of the scan starting at cycle 500.
    waitCycle(522);
    rst = 1'b1;
    applyStimulus(1'b0, 16'h0000, 1'b0, KIND_PINS, 8'h01, "pins_clk_hi_b4");
    applyStimulus(1'b0, 16'h0000, 1'b0, KIND_PINS, 8'h00, "pins_after_rst");
    applyStimulus(1'b0, 16'h4016, 1'b0, KIND_DOUT, 8'h00, "dout_in_rst");
    rst = 1'b0;
    pat1 = 8'h5A;
    waitCycle(20);
    strobeReload();
    readSeq(16'h4016, 8'h00, "aborted_snap1");
    waitCycle(140);
    strobeReload();
    readSeq(16'h4016, 8'h5A, "post_rst_scan");

    idleCycle();
    idleCycle();
    checkOutput("sb_drain", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
